matrix_writeback_controller: RTL
================================

Name: matrix_writeback_controller

Overview:
- Return path of the brightness pipeline: accepts processed 4x4 chunk rows from the TPU/systolic array and writes them back into the 8-bit image RAM.
- Each TPU beat carries one chunk row of four 16-bit results. The block converts each result to an 8-bit pixel and issues four serial RAM writes at the matching image addresses.
- Chunk order and element packing mirror the read-side controller, so a frame read out and written back lands in place.

Parameters:
- MATRIX_SIZE, 8, image side length in pixels; must be a multiple of 4 and at least 4.
- DATA_W, 16, width of one TPU result lane. The bus is 4*DATA_W wide; chunk size is fixed at 4.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; arms a full-frame writeback
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  one-cycle pulse after the last RAM write of the frame
- tpu_result_arr  input  4*DATA_W  one chunk row; lane k = bits [k*DATA_W +: DATA_W] = column k
- tpu_result_valid  input  1  result beat present
- result_ready  output  1  block can accept a beat
- ram_wr_addr  output  clog2(MATRIX_SIZE*MATRIX_SIZE)  pixel write address (6 bits at default)
- ram_wr_data  output  8  pixel value
- ram_we  output  1  write strobe, one pixel per cycle

Behaviour:
- Reset: all outputs are 0, all counters are 0, state is IDLE. Reset wins over every other input in the same cycle.
- States: IDLE, WAIT_BEAT, WRITE, DONE.
- IDLE: when start=1, go to WAIT_BEAT, clear counters, and set busy=1 on the next cycle. A start pulse in any other state is ignored.
- WAIT_BEAT:
  - result_ready=1.
  - On tpu_result_valid && result_ready, latch the 4 lanes and go to WRITE.
  - tpu_result_valid low means stay in this state; idle cycles are allowed.
- WRITE:
  - result_ready=0; beats offered in this state are not accepted.
  - Four consecutive cycles with ram_we=1, columns 0..3 in order. The first write occurs the cycle after acceptance.
  - After the 4th write, go to WAIT_BEAT, or to DONE if that was the last row of the last chunk.
  - Steady-state throughput is 1 beat per 5 cycles.
- Counters: col (0..3), row (0..3), chunk_c (0..MATRIX_SIZE/4-1), chunk_r (0..MATRIX_SIZE/4-1).
  - Chunk order is row-major: chunk_c increments first and wraps to 0 while chunk_r increments.
  - At default size the chunk origins are (0,0), (0,4), (4,0), (4,4).
- Address: ram_wr_addr = (chunk_r*4 + row)*MATRIX_SIZE + chunk_c*4 + col. Compute it without overflow at the output width.
- Pixel conversion: defined under Optional Feature. Lanes are interpreted as signed DATA_W.
- DONE: done=1 for exactly one cycle, busy drops to 0 in the same cycle, then go to IDLE.
- Frame length: (MATRIX_SIZE/4)^2*4 beats, which is 16 beats / 64 writes at default.
- Reset mid-frame: immediately go to IDLE with outputs at 0. Already-written pixels stay as written, and no done pulse is issued.
- ram_wr_addr and ram_wr_data hold their last values when ram_we=0; only ram_we qualifies a write.

Optional Feature:
- Macro WRITEBACK_SATURATE_EN.
- Defined: clamp each lane to the pixel range.
  - Negative values write 0.
  - Values above 255 write 255.
  - Otherwise write the low 8 bits.
- Undefined: write lane[7:0] with no clamping. This is a smaller area option for filters proven not to overflow.

Test Plan:
- Full frame, WRITEBACK_SATURATE_EN defined: drive 16 beats, each with values 1..64 in image order matching the read-side chunking, tpu_result_valid held high. Required response:
  - exactly 64 writes, and RAM[i]=i+1 for all i;
  - the first beat writes addresses 0,1,2,3;
  - beat 5 (chunk 1, row 0) writes 4,5,6,7;
  - beat 9 (chunk 2, row 0) writes 32,33,34,35;
  - done pulses once after address 63 and the cycle count is 80 beat cycles.
- Saturation, WRITEBACK_SATURATE_EN defined: lanes {0x0100, 0xFFFF, 0x00FF, 0x7FFF} -> data 255, 0, 255, 255 to addresses 0..3.
- Truncation, WRITEBACK_SATURATE_EN undefined: same beat -> data 0x00, 0xFF, 0xFF, 0xFF.
- Backpressure and gaps:
  - random idle cycles on tpu_result_valid -> no writes while in WAIT_BEAT;
  - result_ready is never high during WRITE;
  - the beat presented during WRITE is accepted only after returning to WAIT_BEAT;
  - the address sequence is unchanged.
- Start while busy: pulse start at beat 7 -> ignored; the frame completes normally with a single done pulse.
- Reset mid-frame: assert reset after 6 beats -> the next cycle shows ram_we, busy and result_ready at 0 and no done pulse. A new start then writes from address 0 again.

Source files
------------

// File: rtl/matrix_writeback_if.sv
// matrix_writeback_if
// Groups the control, TPU result and RAM write signals of the writeback
// controller.
//   slave  : the controller side (takes start/results, drives status and RAM writes)
//   master : the host/TPU/RAM side
// Signals:
//   start, busy, done                   frame control and status
//   tpu_result_arr, tpu_result_valid,   one chunk row of four signed lanes
//   result_ready                        beat handshake
//   ram_wr_addr, ram_wr_data, ram_we    serial pixel writes into the image RAM
interface matrix_writeback_if #(
  parameter int MATRIX_SIZE = 8,
  parameter int DATA_W      = 16
);
  localparam int ADDR_W = $clog2(MATRIX_SIZE * MATRIX_SIZE);

  logic                  start;
  logic                  busy;
  logic                  done;
  logic [4*DATA_W-1:0]   tpu_result_arr;
  logic                  tpu_result_valid;
  logic                  result_ready;
  logic [ADDR_W-1:0]     ram_wr_addr;
  logic [7:0]            ram_wr_data;
  logic                  ram_we;

  modport slave (
    input  start, tpu_result_arr, tpu_result_valid,
    output busy, done, result_ready, ram_wr_addr, ram_wr_data, ram_we
  );

  modport master (
    output start, tpu_result_arr, tpu_result_valid,
    input  busy, done, result_ready, ram_wr_addr, ram_wr_data, ram_we
  );
endinterface

// File: rtl/matrix_writeback_controller.sv
// matrix_writeback_controller
// Accepts 4x4 chunk rows from the TPU and writes them back, one pixel per
// cycle, into the 8-bit image RAM. Chunks are walked row-major (chunk column
// first), matching the read-side controller so frames land in place.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    matrix_writeback_if.slave (start/busy/done, TPU beat handshake,
//          RAM write port)
// Build option:
//   WRITEBACK_SATURATE_EN  defined   : clamp signed lanes to 0..255
//                          undefined : write lane[7:0] unclamped
//
// state     | meaning
// IDLE      | waiting for start
// WAIT_BEAT | result_ready high, waiting for a chunk row
// WRITE     | four serial pixel writes, columns 0..3
// DONE      | one-cycle done pulse, then back to IDLE
module matrix_writeback_controller #(
  parameter int MATRIX_SIZE = 8,
  parameter int DATA_W      = 16
) (
  input logic               clk,
  input logic               reset,
  matrix_writeback_if.slave bus
);
  localparam int N_CHUNK = MATRIX_SIZE / 4;
  localparam int CW      = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam int ADDR_W  = $clog2(MATRIX_SIZE * MATRIX_SIZE);
  localparam logic [CW-1:0] CHUNK_LAST = CW'(N_CHUNK - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BEAT, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic [1:0]        row_q, row_d;
  logic [CW-1:0]     chunk_c_q, chunk_c_d;
  logic [CW-1:0]     chunk_r_q, chunk_r_d;
  logic [3:0][7:0]   pix_q, pix_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [7:0]        data_hold_q, data_hold_d;

  logic [3:0][7:0]   conv;
  logic [ADDR_W-1:0] pix_y, pix_x, addr_cur;

  // Lanes are converted at acceptance so only 8 bits per column are held.
  for (genvar k = 0; k < 4; k++) begin : gen_lane
    logic [DATA_W-1:0] lane;
    assign lane = bus.tpu_result_arr[k*DATA_W +: DATA_W];
`ifdef WRITEBACK_SATURATE_EN
    assign conv[k] = lane[DATA_W-1]      ? 8'd0  :
                     (|lane[DATA_W-2:8]) ? 8'hFF : lane[7:0];
`else
    logic unused_hi;
    assign unused_hi = ^lane[DATA_W-1:8];
    assign conv[k]   = lane[7:0];
`endif
  end

  // {chunk, row} equals chunk*4 + row; widening first keeps the product exact.
  assign pix_y    = ADDR_W'({chunk_r_q, row_q});
  assign pix_x    = ADDR_W'({chunk_c_q, col_q});
  assign addr_cur = pix_y * ADDR_W'(MATRIX_SIZE) + pix_x;

  assign bus.ram_we       = (state_q == WRITE);
  assign bus.ram_wr_addr  = bus.ram_we ? addr_cur     : addr_hold_q;
  assign bus.ram_wr_data  = bus.ram_we ? pix_q[col_q] : data_hold_q;
  assign bus.result_ready = (state_q == WAIT_BEAT);
  assign bus.busy         = (state_q == WAIT_BEAT) || (state_q == WRITE);
  assign bus.done         = (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    chunk_c_d   = chunk_c_q;
    chunk_r_d   = chunk_r_q;
    pix_d       = pix_q;
    addr_hold_d = addr_hold_q;
    data_hold_d = data_hold_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = WAIT_BEAT;
          col_d     = '0;
          row_d     = '0;
          chunk_c_d = '0;
          chunk_r_d = '0;
        end
      end
      WAIT_BEAT: begin
        if (bus.tpu_result_valid) begin
          pix_d   = conv;
          col_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        addr_hold_d = addr_cur;
        data_hold_d = pix_q[col_q];
        if (col_q == 2'd3) begin
          col_d   = '0;
          state_d = WAIT_BEAT;
          if (row_q == 2'd3) begin
            row_d = '0;
            if (chunk_c_q == CHUNK_LAST) begin
              chunk_c_d = '0;
              if (chunk_r_q == CHUNK_LAST) begin
                chunk_r_d = '0;
                state_d   = DONE;
              end else begin
                chunk_r_d = chunk_r_q + 1'b1;
              end
            end else begin
              chunk_c_d = chunk_c_q + 1'b1;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      chunk_c_q   <= '0;
      chunk_r_q   <= '0;
      pix_q       <= '0;
      addr_hold_q <= '0;
      data_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      chunk_c_q   <= chunk_c_d;
      chunk_r_q   <= chunk_r_d;
      pix_q       <= pix_d;
      addr_hold_q <= addr_hold_d;
      data_hold_q <= data_hold_d;
    end
  end
endmodule
